// File: rtl/clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// clb_cfg_loader
//
// Serial configuration loader for an array of clb18-style CLBs. A bit-serial
// stream (MSB first) is scanned for the preamble 4'b0010. The frame count that
// follows is checked against N_CLB. One even-parity frame per CLB is then
// collected into a shadow store, and after a 4'b1111 postamble all frames are
// committed to CFG_OUT in a single cycle. GHOLD (= BUSY) freezes the CLB flops
// while a load is in progress.
//
// Ports
//   K          clock, all logic on the rising edge
//   RST        synchronous active-high reset (wins over everything)
//   PROG       1-cycle pulse: start or restart a load
//   DIN        serial config bit, MSB first
//   DIN_VALID  DIN is consumed only when high; low cycles are stalls
//   CFG_OUT    committed config, CLB i = CFG_OUT[i*CFG_W +: CFG_W]
//   BUSY       load in progress (SYNC .. COMMIT)
//   GHOLD      copy of BUSY for the CLB array
//   DONE       last load committed; held until the next PROG or RST
//   ERR        last load aborted; held until the next PROG or RST
//
// Frame layout (MSB first): mux2sel[2] mux3sel[2] mux4sel[2] mux5sel[2]
// mux6sel[2] mem[16] comboption[2] o2m1_0 o2m2_0 o2m3_0 o2m1_1 o2m2_1 o2m3_1
// DQmux1 DQmux2 floporlatch, then one parity bit (XOR of all 38 bits = 0).
// -----------------------------------------------------------------------------
module clb_cfg_loader #(
   parameter int N_CLB = 4,
   parameter int CFG_W = 37,
   parameter int LEN_W = 8
) (
   input  logic                   K,
   input  logic                   RST,
   input  logic                   PROG,
   input  logic                   DIN,
   input  logic                   DIN_VALID,
   output logic [N_CLB*CFG_W-1:0] CFG_OUT,
   output logic                   BUSY,
   output logic                   GHOLD,
   output logic                   DONE,
   output logic                   ERR
);

   localparam int FRM_W = CFG_W + 1;
   localparam int IDX_W = (N_CLB > 1) ? $clog2(N_CLB) : 1;
   localparam int CNT_W = $clog2(((FRM_W > LEN_W) ? FRM_W : LEN_W) + 1);

   // Power-up personality of one CLB, fields in frame order.
   localparam logic [CFG_W-1:0] CLB_DEFAULT =
      {2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 16'h0116, 2'b00,
       3'b000, 3'b111, 2'b00, 1'b0};

   typedef enum logic [2:0] {
      IDLE, SYNC, LEN, FRAME, POST, COMMIT, DONE_S, ERR_S
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [2:0]        sync_sr;      // last three stream bits seen in SYNC
   logic [FRM_W-2:0]  data_sr;      // LEN / frame bits collected so far
   logic [CNT_W-1:0]  bit_cnt;      // bits consumed in the current field
   logic [IDX_W-1:0]  frame_idx;
   logic [CFG_W-1:0]  shadow [N_CLB];

   logic              accept;
   logic [3:0]        sync_word;
   logic [FRM_W-1:0]  frame_word;
   logic [LEN_W-1:0]  len_word;
   logic              sync_hit;
   logic              len_last;
   logic              frame_last;
   logic              post_last;
   logic              parity_ok;
   logic              idx_last;

   // PROG on the same cycle as a valid bit discards that bit.
   assign accept     = DIN_VALID & ~PROG;

   // The words below include the bit being accepted this cycle, so each
   // field is decided on the edge that consumes its last bit.
   assign sync_word  = {sync_sr, DIN};
   assign frame_word = {data_sr, DIN};
   assign len_word   = frame_word[LEN_W-1:0];

   // bit_cnt saturates at 3 in SYNC, so the zeros left in sync_sr by the
   // clear on entry can never complete a false preamble.
   assign sync_hit   = (bit_cnt == CNT_W'(3)) && (sync_word == 4'b0010);
   assign len_last   = (bit_cnt == CNT_W'(LEN_W - 1));
   assign frame_last = (bit_cnt == CNT_W'(FRM_W - 1));
   assign post_last  = (bit_cnt == CNT_W'(3));
   assign parity_ok  = ~^frame_word;
   assign idx_last   = (frame_idx == IDX_W'(N_CLB - 1));

   assign BUSY  = (state == SYNC)  || (state == LEN)  || (state == FRAME) ||
                  (state == POST)  || (state == COMMIT);
   assign GHOLD = BUSY;
   assign DONE  = (state == DONE_S);
   assign ERR   = (state == ERR_S);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge K) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: state_nxt is defaulted first so every path assigns it and no
   // latch is inferred.
   always_comb begin
      state_nxt = state;
      if (PROG) begin
         state_nxt = SYNC;
      end else begin
         case (state)
            SYNC: begin
               if (accept && sync_hit) state_nxt = LEN;
            end
            LEN: begin
               if (accept && len_last) begin
                  if (len_word == LEN_W'(N_CLB)) state_nxt = FRAME;
                  else                           state_nxt = ERR_S;
               end
            end
            FRAME: begin
               if (accept && frame_last) begin
                  if (!parity_ok)    state_nxt = ERR_S;
                  else if (idx_last) state_nxt = POST;
               end
            end
            POST: begin
               if (accept) begin
                  if (!DIN)           state_nxt = ERR_S;
                  else if (post_last) state_nxt = COMMIT;
               end
            end
            COMMIT:  state_nxt = DONE_S;
            default: state_nxt = state;   // IDLE, DONE_S, ERR_S wait for PROG
         endcase
      end
   end

   // Stream datapath. Nothing moves on stall cycles.
   // NOTE: the shadow store is reset explicitly because a restarted load
   // must never commit frames left over from an earlier attempt.
   always_ff @(posedge K) begin
      if (RST || PROG) begin
         sync_sr   <= '0;
         data_sr   <= '0;
         bit_cnt   <= '0;
         frame_idx <= '0;
         for (int i = 0; i < N_CLB; i++) shadow[i] <= '0;
      end else if (accept) begin
         case (state)
            SYNC: begin
               sync_sr <= sync_word[2:0];
               if (sync_hit)                   bit_cnt <= '0;
               else if (bit_cnt != CNT_W'(3))  bit_cnt <= bit_cnt + CNT_W'(1);
            end
            LEN: begin
               data_sr <= frame_word[FRM_W-2:0];
               bit_cnt <= len_last ? '0 : bit_cnt + CNT_W'(1);
            end
            FRAME: begin
               data_sr <= frame_word[FRM_W-2:0];
               if (frame_last) begin
                  bit_cnt <= '0;
                  if (parity_ok) begin
                     shadow[frame_idx] <= frame_word[FRM_W-1:1];
                     if (!idx_last) frame_idx <= frame_idx + IDX_W'(1);
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            POST: begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Committed configuration: only reset and COMMIT ever change it, which
   // keeps every load atomic from the CLB array's point of view.
   always_ff @(posedge K) begin
      if (RST) begin
         for (int i = 0; i < N_CLB; i++) CFG_OUT[i*CFG_W +: CFG_W] <= CLB_DEFAULT;
      end else if (state == COMMIT) begin
         for (int i = 0; i < N_CLB; i++) CFG_OUT[i*CFG_W +: CFG_W] <= shadow[i];
      end
   end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_clb_cfg_loader
//
// Self-checking bench for clb_cfg_loader. Each complete stream is parsed by a
// stream-level reference model that predicts commit/abort and the resulting
// CFG_OUT; the prediction is queued and a monitor compares it when DONE or
// ERR rises. Directed checks cover reset, latency, abort timing, restart and
// reset mid-load.
// -----------------------------------------------------------------------------
module tb_clb_cfg_loader;

   localparam int N_CLB = 4;
   localparam int CFG_W = 37;
   localparam int LEN_W = 8;
   localparam int FRM_W = CFG_W + 1;
   localparam int TOT_W = N_CLB * CFG_W;

   typedef logic [CFG_W-1:0] clb_t;
   typedef struct {
      bit               ok;
      logic [TOT_W-1:0] cfg;
   } exp_t;

   logic             K = 1'b0;
   logic             RST;
   logic             PROG;
   logic             DIN;
   logic             DIN_VALID;
   logic [TOT_W-1:0] CFG_OUT;
   logic             BUSY;
   logic             GHOLD;
   logic             DONE;
   logic             ERR;

   clb_cfg_loader #(.N_CLB(N_CLB), .CFG_W(CFG_W), .LEN_W(LEN_W)) dut (
      .K         (K),
      .RST       (RST),
      .PROG      (PROG),
      .DIN       (DIN),
      .DIN_VALID (DIN_VALID),
      .CFG_OUT   (CFG_OUT),
      .BUSY      (BUSY),
      .GHOLD     (GHOLD),
      .DONE      (DONE),
      .ERR       (ERR)
   );

   always #5 K = ~K;

   int               errors = 0;
   int               checks = 0;
   exp_t             sb[$];
   bit               stream[$];
   logic [2:0]       snap[$];      // {BUSY, ERR, DONE} after each accepted bit
   logic [2:0]       stall_flags;
   logic [TOT_W-1:0] committed;    // model of the committed configuration

   task automatic check(input string name, input logic [TOT_W-1:0] act,
                        input logic [TOT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reset personality of one CLB, written field by field.
   function automatic clb_t default_clb();
      clb_t c;
      c          = '0;
      c[36:35]   = 2'b10;     // mux2sel
      c[34:33]   = 2'b10;     // mux3sel
      c[32:31]   = 2'b10;     // mux4sel
      c[26:11]   = 16'h0116;  // mem
      c[5]       = 1'b1;      // o2m1_1
      c[4]       = 1'b1;      // o2m2_1
      c[3]       = 1'b1;      // o2m3_1
      return c;
   endfunction

   function automatic logic [TOT_W-1:0] rand_img();
      logic [TOT_W-1:0] img;
      img = '0;
      for (int f = 0; f < N_CLB; f++) img[f*CFG_W +: CFG_W] = CFG_W'({$urandom(), $urandom()});
      return img;
   endfunction

   // Builds a stream: lead 1s, preamble, LEN, frames (CLB0 first), postamble.
   task automatic build(input logic [TOT_W-1:0] img, input int lead,
                        input logic [LEN_W-1:0] len, input int flip_frame,
                        input logic [3:0] post);
      logic [3:0] pre;
      clb_t       d;
      bit         p;
      pre = 4'b0010;
      stream.delete();
      repeat (lead) stream.push_back(1'b1);
      for (int b = 3; b >= 0; b--) stream.push_back(pre[b]);
      for (int b = LEN_W - 1; b >= 0; b--) stream.push_back(len[b]);
      for (int f = 0; f < N_CLB; f++) begin
         d = img[f*CFG_W +: CFG_W];
         p = 1'b0;
         for (int b = CFG_W - 1; b >= 0; b--) begin
            stream.push_back(d[b]);
            p = p ^ d[b];
         end
         if (f == flip_frame) p = ~p;
         stream.push_back(p);
      end
      for (int b = 3; b >= 0; b--) stream.push_back(post[b]);
   endtask

   // Reference model: parses the whole stream and predicts the outcome.
   function automatic exp_t model(input logic [TOT_W-1:0] prev);
      exp_t             r;
      int               p;
      int               len;
      int               ones;
      clb_t             d;
      logic [TOT_W-1:0] img;
      r.ok  = 1'b0;
      r.cfg = prev;
      p     = -1;
      for (int i = 3; i < stream.size(); i++)
         if (p < 0 && stream[i-3] == 0 && stream[i-2] == 0 && stream[i-1] == 1 && stream[i] == 0)
            p = i + 1;
      if (p < 0 || p + LEN_W > stream.size()) return r;
      len = 0;
      for (int k = 0; k < LEN_W; k++) len = len * 2 + int'(stream[p+k]);
      p += LEN_W;
      if (len != N_CLB) return r;
      img = '0;
      for (int f = 0; f < N_CLB; f++) begin
         if (p + FRM_W > stream.size()) return r;
         ones = 0;
         d    = '0;
         for (int k = 0; k < FRM_W; k++) ones += int'(stream[p+k]);
         for (int k = 0; k < CFG_W; k++) d = {d[CFG_W-2:0], stream[p+k]};
         if (ones % 2 != 0) return r;
         img[f*CFG_W +: CFG_W] = d;
         p += FRM_W;
      end
      for (int k = 0; k < 4; k++)
         if (p + k >= stream.size() || stream[p+k] == 0) return r;
      r.ok  = 1'b1;
      r.cfg = img;
      return r;
   endfunction

   task automatic expect_load();
      exp_t e;
      e = model(committed);
      sb.push_back(e);
      if (e.ok) committed = e.cfg;
   endtask

   task automatic prog();
      PROG      = 1'b1;
      DIN_VALID = 1'b1;
      DIN       = 1'($urandom());
      @(posedge K); #1;
      PROG      = 1'b0;
      DIN_VALID = 1'b0;
   endtask

   // Sends the first n_bits of the stream (all if negative) with random
   // stalls; an optional 20-cycle stall precedes bit stall_at.
   task automatic send(input int gap_pct, input int n_bits, input int stall_at);
      int n;
      n = (n_bits < 0) ? stream.size() : n_bits;
      snap.delete();
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) begin
            DIN_VALID = 1'b0;
            DIN       = 1'($urandom());
            repeat (20) @(posedge K);
            #1;
            stall_flags = {BUSY, ERR, DONE};
         end
         while (int'($urandom_range(99)) < gap_pct) begin
            DIN_VALID = 1'b0;
            DIN       = 1'($urandom());
            @(posedge K); #1;
         end
         DIN_VALID = 1'b1;
         DIN       = stream[i];
         @(posedge K); #1;
         snap.push_back({BUSY, ERR, DONE});
      end
      DIN_VALID = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 50;
      while (sb.size() > 0 && budget > 0) begin
         @(posedge K); #1;
         budget--;
      end
      check("scoreboard_drained", TOT_W'(sb.size()), '0);
   endtask

   // Monitor: compares each DONE/ERR rise against the oldest prediction and
   // flags any CFG_OUT change that is not a commit.
   exp_t             mon_e;
   logic [TOT_W-1:0] prev_cfg;
   logic             prev_done;
   logic             prev_err;

   always @(negedge K) begin
      if (!RST) begin
         check("ghold_eq_busy", TOT_W'(GHOLD), TOT_W'(BUSY));
         if ((DONE && !prev_done) || (ERR && !prev_err)) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_outcome: got DONE=%0b ERR=%0b with no load pending", DONE, ERR);
            end else begin
               mon_e = sb.pop_front();
               check("outcome_done", TOT_W'(DONE), TOT_W'(mon_e.ok));
               check("outcome_err", TOT_W'(ERR), TOT_W'(!mon_e.ok));
               check("outcome_cfg", CFG_OUT, mon_e.cfg);
            end
         end else if (CFG_OUT !== prev_cfg) begin
            checks++;
            errors++;
            $display("FAIL cfg_atomic: got %h expected %h", CFG_OUT, prev_cfg);
         end
      end
      prev_cfg  = CFG_OUT;
      prev_done = DONE;
      prev_err  = ERR;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [TOT_W-1:0] img;
      logic [TOT_W-1:0] img2;
      logic [TOT_W-1:0] pre;
      logic [TOT_W-1:0] defaults;
      int               idx;
      int               busy_low;

      RST = 1'b1; PROG = 1'b0; DIN = 1'b0; DIN_VALID = 1'b0;
      repeat (3) @(posedge K);
      #1 RST = 1'b0;
      defaults  = {N_CLB{default_clb()}};
      committed = defaults;

      // Reset state
      check("rst_cfg", CFG_OUT, defaults);
      for (int i = 0; i < N_CLB; i++) begin
         check($sformatf("rst_mem_%0d", i), TOT_W'(CFG_OUT[i*CFG_W+11 +: 16]), TOT_W'(16'h0116));
         check($sformatf("rst_mux2sel_%0d", i), TOT_W'(CFG_OUT[i*CFG_W+35 +: 2]), TOT_W'(2'b10));
         check($sformatf("rst_o2m1_1_%0d", i), TOT_W'(CFG_OUT[i*CFG_W+5]), TOT_W'(1'b1));
      end
      check("rst_busy", TOT_W'(BUSY), '0);
      check("rst_ghold", TOT_W'(GHOLD), '0);
      check("rst_done", TOT_W'(DONE), '0);
      check("rst_err", TOT_W'(ERR), '0);

      // Clean load, CLB2 mem = BEEF
      img2 = rand_img();
      img2[2*CFG_W+11 +: 16] = 16'hBEEF;
      build(img2, 4, 8'd4, -1, 4'hF);
      expect_load();
      pre = CFG_OUT;
      prog();
      check("busy_after_prog", TOT_W'(BUSY), TOT_W'(1'b1));
      send(0, -1, -1);
      busy_low = 0;
      foreach (snap[i]) if (!snap[i][2]) busy_low++;
      check("busy_during_load", TOT_W'(busy_low), '0);
      check("cfg_held_until_commit", CFG_OUT, pre);
      check("done_one_after_last", TOT_W'(DONE), '0);
      @(posedge K); #1;
      check("done_two_after_last", TOT_W'(DONE), TOT_W'(1'b1));
      check("busy_after_done", TOT_W'(BUSY), '0);
      check("clb2_mem", TOT_W'(CFG_OUT[2*CFG_W+11 +: 16]), TOT_W'(16'hBEEF));
      drain();

      // CLB1 parity flipped
      build(img2, 4, 8'd4, 1, 4'hF);
      expect_load();
      pre = CFG_OUT;
      prog();
      send(0, -1, -1);
      idx = 4 + 4 + LEN_W + 2 * FRM_W - 1;
      check("err_before_frame1_end", TOT_W'(snap[idx-1][1]), '0);
      check("err_after_frame1", TOT_W'(snap[idx][1]), TOT_W'(1'b1));
      check("busy_after_parity_err", TOT_W'(snap[idx][2]), '0);
      check("cfg_after_parity_err", CFG_OUT, pre);
      drain();

      // Wrong frame count
      build(rand_img(), 3, 8'd3, -1, 4'hF);
      expect_load();
      pre = CFG_OUT;
      prog();
      send(0, -1, -1);
      idx = 3 + 4 + LEN_W - 1;
      check("err_before_len_end", TOT_W'(snap[idx-1][1]), '0);
      check("err_after_len", TOT_W'(snap[idx][1]), TOT_W'(1'b1));
      check("cfg_after_len_err", CFG_OUT, pre);
      drain();

      // Bad postamble
      build(rand_img(), 5, 8'd4, -1, 4'b1101);
      expect_load();
      prog();
      send(0, -1, -1);
      repeat (2) @(posedge K);
      #1;
      check("post_err", TOT_W'(ERR), TOT_W'(1'b1));
      check("post_no_done", TOT_W'(DONE), '0);
      check("cfg_after_post_err", CFG_OUT, pre);
      drain();

      // Stalls: a different load with a long mid-frame stall, then the
      // BEEF stream with ~50% gaps
      img = rand_img();
      build(img, 2, 8'd4, -1, 4'hF);
      expect_load();
      prog();
      send(50, -1, 4 + 4 + LEN_W + FRM_W + 17);
      check("stall_flags", TOT_W'(stall_flags), TOT_W'(3'b100));
      drain();
      check("cfg_after_stall_load", CFG_OUT, img);
      build(img2, 4, 8'd4, -1, 4'hF);
      expect_load();
      prog();
      send(50, -1, -1);
      drain();
      check("cfg_gapped_repeat", CFG_OUT, img2);

      // Random loads with occasional corruption
      for (int it = 0; it < 8; it++) begin
         logic [LEN_W-1:0] len;
         logic [3:0]       post;
         int               flip;
         len  = ($urandom_range(5) == 0) ? LEN_W'($urandom_range(7)) : LEN_W'(N_CLB);
         flip = ($urandom_range(4) == 0) ? int'($urandom_range(N_CLB - 1)) : -1;
         post = ($urandom_range(4) == 0) ? 4'($urandom()) : 4'hF;
         build(rand_img(), int'($urandom_range(6)), len, flip, post);
         expect_load();
         prog();
         send(int'($urandom_range(60)), -1, -1);
         repeat (2) @(posedge K);
         #1;
         drain();
      end

      // PROG mid-frame 2, then a full second stream
      build(rand_img(), 4, 8'd4, -1, 4'hF);
      prog();
      send(20, 4 + 4 + LEN_W + 2 * FRM_W + 15, -1);
      img = rand_img();
      build(img, 3, 8'd4, -1, 4'hF);
      expect_load();
      prog();
      send(20, -1, -1);
      drain();
      check("cfg_restarted_load", CFG_OUT, img);

      // RST mid-load
      build(rand_img(), 4, 8'd4, -1, 4'hF);
      prog();
      send(0, 60, -1);
      RST = 1'b1;
      repeat (2) @(posedge K);
      #1 RST = 1'b0;
      committed = defaults;
      check("rst_mid_cfg", CFG_OUT, defaults);
      check("rst_mid_busy", TOT_W'(BUSY), '0);
      check("rst_mid_done", TOT_W'(DONE), '0);
      check("rst_mid_err", TOT_W'(ERR), '0);

      // IDLE ignores a stream without PROG
      img = rand_img();
      build(img, 4, 8'd4, -1, 4'hF);
      send(0, -1, -1);
      repeat (3) @(posedge K);
      #1;
      check("idle_busy", TOT_W'(BUSY), '0);
      check("idle_done", TOT_W'(DONE), '0);
      check("idle_cfg", CFG_OUT, defaults);

      // Recovery after reset
      expect_load();
      prog();
      send(30, -1, -1);
      drain();
      check("cfg_after_recovery", CFG_OUT, img);

      repeat (3) @(posedge K);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
